muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative unsigned multiply/divide sequencer in the EX stage of the MIPS pipeline. It recognises MUL/DIV R-type instructions held in the ID/EX register and runs them on one shared shift/add-subtract datapath over WIDTH cycles. While it works it stalls the pipeline, then writes the HI/LO result registers. Ordinary ALU operations bypass it with no stall.

## Interface
- WIDTH, 32, operand width; HI/LO are each WIDTH bits
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash the ID/EX instruction; aborts any operation in progress
- valid_idex  in  1  ID/EX holds a valid instruction
- alu_op_idex  in  3  ALU op class from the main decoder (3'b010 = R-type)
- func_idex  in  6  R-type function field
- opa  in  WIDTH  rs operand (multiplicand / dividend)
- opb  in  WIDTH  rt operand (multiplier / divisor)
- stall  out  1  freeze IF/ID and ID/EX; combinational
- busy  out  1  state is RUN (registered)
- done  out  1  one-cycle pulse; HI/LO updated and valid
- hi  out  WIDTH  MUL: upper product half; DIV: remainder
- lo  out  WIDTH  MUL: lower product half; DIV: quotient

## Operation
- Decode:
  - is_mul = valid_idex & alu_op_idex==3'b010 & func_idex==6'b011000
  - is_div = the same condition with func_idex==6'b011010
  - req = is_mul | is_div
- States are IDLE, RUN and DONE.
- IDLE:
  - Default next state is IDLE.
  - If req & !flush: latch opa/opb and the op type, clear count, clear the accumulator. Next state is RUN.
  - Exception: DIV with opb==0 goes straight to DONE, with lo=all ones and hi=opa.
- RUN: one iteration per cycle while count runs 0..WIDTH-1.
  - MUL uses shift-add on a 2*WIDTH accumulator, LSB-first on the multiplier.
  - DIV uses restoring division: shift the remainder left by one, bring in the next dividend MSB, trial-subtract the divisor, keep the result if it is non-negative, and shift in the quotient bit.
  - In the iteration where count==WIDTH-1, register the final HI/LO. Next state is DONE.
- DONE: assert done and go to IDLE unconditionally. The decoder is ignored in this state, because the stalled instruction is still in ID/EX and must not restart.
- stall = (IDLE & req & !flush) | RUN. It is 0 in DONE, so the completed instruction advances at the end of the DONE cycle.
- flush in RUN: go to IDLE, no done pulse, HI/LO unchanged. flush has priority over req.
- hi/lo hold their value until the next completed operation. Aborted operations never modify them.
- All arithmetic is unsigned. Overflow is impossible: the product fits in 2*WIDTH bits and the quotient is at most the dividend.

## Timing
- Reset: state=IDLE, count=0, hi=0, lo=0, done=0, busy=0, stall=0. Reset applies mid-operation with the same result, and rst overrides flush and req.
- Instruction first valid in ID/EX in cycle T (IDLE):
  - stall=1 in T.
  - busy=1 and stall=1 in T+1..T+WIDTH.
  - done=1, stall=0 and HI/LO new in T+WIDTH+1.
  - Total pipeline stall is WIDTH+1 cycles.
- Divide by zero: stall=1 in T only; done=1 in T+1.
- Back-to-back MUL/DIV: the second instruction enters ID/EX after DONE and is seen in IDLE at T+WIDTH+2, so there is zero extra gap.
- Non-MUL/DIV instruction: stall=0, state stays IDLE, outputs unchanged.
- done is never asserted in two consecutive cycles.

## Test plan
- Reset, then idle: hi=lo=0, stall=busy=done=0. Then alu_op_idex=3'b011 valid gives stall=0 throughout.
- MUL 7×6 at cycle T (WIDTH=32): stall=1 in T..T+32, done in T+33 with hi=0, lo=42.
- MUL 0xFFFFFFFF×0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001, done after 33 stall cycles. Follow immediately with MUL 3×5: second done 34 cycles after the first, hi=0, lo=15.
- DIV 100/7: lo=14, hi=2. DIV 5/7: lo=0, hi=5. DIV 5/0: stall only in T, done in T+1, lo=0xFFFFFFFF, hi=5.
- After a MUL that leaves hi=0, lo=42, start DIV 100/7 and assert flush at T+10: state IDLE at T+11, no done pulse, hi/lo stay 0/42.
- MUL 7×6 with rst asserted at T+5: all outputs are at reset values at T+6. A new MUL 2×3 then completes normally with lo=6.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/DIV unit for the EX stage: one shared shift/add-subtract
// datapath, WIDTH iterations per operation, stalling the pipeline while it runs.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             valid_idex,
    input  logic [2:0]       alu_op_idex,
    input  logic [5:0]       func_idex,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CW-1:0]      r_count;
    logic               r_isDiv;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_accNext;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem;
    logic               w_qBit;
    logic               w_isMul;
    logic               w_isDiv;
    logic               w_req;
    logic               w_start;
    logic               w_divZero;
    logic               w_last;

    assign w_isMul   = valid_idex && (alu_op_idex == 3'b010) && (func_idex == 6'b011000);
    assign w_isDiv   = valid_idex && (alu_op_idex == 3'b010) && (func_idex == 6'b011010);
    assign w_req     = w_isMul || w_isDiv;
    assign w_start   = (r_state == IDLE) && w_req && !flush;
    assign w_divZero = w_isDiv && (opb == '0);
    assign w_last    = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // DONE ignores the decoder: the finished instruction is still sitting in ID/EX.
    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    stall       = 1'b1;
                    w_nextState = w_divZero ? DONE : RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (flush)       w_nextState = IDLE;
                else if (w_last) w_nextState = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // MUL: upper half accumulates, whole accumulator shifts right. DIV: upper half
    // is the partial remainder, lower half collects quotient bits from the right.
    always_comb begin
        w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_opB[0] ? r_opA : '0)};
        w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_opA[WIDTH-1]};
        w_qBit    = (w_trial >= {1'b0, r_opB});
        w_rem     = w_qBit ? WIDTH'(w_trial - {1'b0, r_opB}) : w_trial[WIDTH-1:0];
        w_accNext = r_isDiv ? {w_rem, r_acc[WIDTH-2:0], w_qBit}
                            : {w_mulSum, r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_isDiv <= 1'b0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_opA   <= opa;
                        r_opB   <= opb;
                        r_isDiv <= w_isDiv;
                        r_count <= '0;
                        r_acc   <= '0;
                        if (w_divZero) begin
                            r_hi <= opa;
                            r_lo <= '1;
                        end
                    end
                end
                RUN: begin
                    if (!flush) begin
                        r_acc   <= w_accNext;
                        r_count <= r_count + 1'b1;
                        if (r_isDiv) r_opA <= r_opA << 1;
                        else         r_opB <= r_opB >> 1;
                        if (w_last) begin
                            r_hi <= w_accNext[2*WIDTH-1:WIDTH];
                            r_lo <= w_accNext[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer; HI/LO expectations come
// from plain 64-bit multiply, divide and modulo.
module tb_muldiv_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             valid_idex;
    logic [2:0]       alu_op_idex;
    logic [5:0]       func_idex;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int vectors     = 0;
    int miscompares = 0;
    int cycleCount  = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_idex(valid_idex),
        .alu_op_idex(alu_op_idex), .func_idex(func_idex), .opa(opa), .opb(opb),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    function automatic logic [63:0] refResult(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
        if (!isDiv)     return {32'b0, a} * {32'b0, b};
        else if (b == 0) return {a, 32'hFFFF_FFFF};
        else            return {a % b, a / b};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b, input logic fl);
        valid_idex  = v;
        alu_op_idex = op;
        func_idex   = fn;
        opa         = a;
        opb         = b;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic goIdle();
        tick();
        applyStimulus(1'b0, 3'b000, 6'b0, 32'b0, 32'b0, 1'b0);
        @(negedge clk);
        checkOutput("idle done", done, 1'b0);
        checkOutput("idle stall", stall, 1'b0);
    endtask

    // The instruction is held in ID/EX until the done cycle, as a stalled pipeline would.
    task automatic runOp(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                         input string tag, output int doneCycle);
        logic [63:0] expected;
        int          latency;
        expected = refResult(isDiv, a, b);
        latency  = (isDiv && b == 0) ? 1 : WIDTH + 1;
        tick();
        applyStimulus(1'b1, 3'b010, isDiv ? 6'b011010 : 6'b011000, a, b, 1'b0);
        @(negedge clk);
        checkOutput({tag, " stallT"}, stall, 1'b1);
        checkOutput({tag, " busyT"}, busy, 1'b0);
        for (int k = 1; k < latency; k++) begin
            tick();
            @(negedge clk);
            checkOutput($sformatf("%s stall%0d", tag, k), stall, 1'b1);
            checkOutput($sformatf("%s busy%0d", tag, k), busy, 1'b1);
            checkOutput($sformatf("%s done%0d", tag, k), done, 1'b0);
        end
        tick();
        @(negedge clk);
        checkOutput({tag, " done"}, done, 1'b1);
        checkOutput({tag, " stallD"}, stall, 1'b0);
        checkOutput({tag, " busyD"}, busy, 1'b0);
        checkOutput({tag, " hi"}, hi, expected[63:32]);
        checkOutput({tag, " lo"}, lo, expected[31:0]);
        doneCycle = cycleCount;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d1;
        int d2;
        bit isDiv;
        logic [31:0] a;
        logic [31:0] b;

        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 6'b0, 32'b0, 32'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset stall", stall, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);

        for (int k = 0; k < 3; k++) begin
            tick();
            applyStimulus(1'b1, 3'b011, 6'b011000, 32'd7, 32'd6, 1'b0);
            @(negedge clk);
            checkOutput("alu bypass stall", stall, 1'b0);
            checkOutput("alu bypass busy", busy, 1'b0);
        end
        tick();
        applyStimulus(1'b1, 3'b010, 6'b100000, 32'd7, 32'd6, 1'b0);
        @(negedge clk);
        checkOutput("add bypass stall", stall, 1'b0);
        checkOutput("add bypass lo", lo, 32'h0);

        runOp(1'b0, 32'd7, 32'd6, "mul 7x6", d1);
        goIdle();

        runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul max", d1);
        runOp(1'b0, 32'd3, 32'd5, "mul 3x5", d2);
        checkOutput("back-to-back gap", 64'(d2 - d1), 64'd34);
        goIdle();

        runOp(1'b1, 32'd100, 32'd7, "div 100/7", d1);
        runOp(1'b1, 32'd5, 32'd7, "div 5/7", d1);
        runOp(1'b1, 32'd5, 32'd0, "div 5/0", d1);
        goIdle();

        runOp(1'b0, 32'd7, 32'd6, "mul pre-flush", d1);
        tick();
        applyStimulus(1'b1, 3'b010, 6'b011010, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        checkOutput("flush stallT", stall, 1'b1);
        for (int k = 1; k < 10; k++) begin
            tick();
            @(negedge clk);
            checkOutput("flush run busy", busy, 1'b1);
        end
        tick();
        applyStimulus(1'b1, 3'b010, 6'b011010, 32'd100, 32'd7, 1'b1);
        @(negedge clk);
        checkOutput("flush cycle busy", busy, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 6'b0, 32'b0, 32'b0, 1'b0);
        @(negedge clk);
        checkOutput("after flush busy", busy, 1'b0);
        checkOutput("after flush stall", stall, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("after flush done", done, 1'b0);
            checkOutput("after flush hi", hi, 32'd0);
            checkOutput("after flush lo", lo, 32'd42);
            tick();
            @(negedge clk);
        end

        tick();
        applyStimulus(1'b1, 3'b010, 6'b011000, 32'd7, 32'd6, 1'b0);
        for (int k = 1; k < 5; k++) begin
            tick();
            @(negedge clk);
            checkOutput("pre-reset busy", busy, 1'b1);
        end
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 6'b0, 32'b0, 32'b0, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid reset stall", stall, 1'b0);
        checkOutput("mid reset busy", busy, 1'b0);
        checkOutput("mid reset done", done, 1'b0);
        checkOutput("mid reset hi", hi, 32'h0);
        checkOutput("mid reset lo", lo, 32'h0);
        runOp(1'b0, 32'd2, 32'd3, "mul 2x3", d1);
        goIdle();

        for (int i = 0; i < 8; i++) begin
            isDiv = bit'($urandom_range(0, 1));
            a     = $urandom;
            if (i == 3)                       b = 32'd0;
            else if ($urandom_range(0, 1) == 1) b = $urandom;
            else                              b = $urandom_range(1, 255);
            runOp(isDiv, a, b, $sformatf("rand%0d %s %0h,%0h", i, isDiv ? "div" : "mul", a, b), d1);
            goIdle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
